// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath connection: instruction/flags in, bus select and load strobes out.
interface control_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] instr;
    logic              flag_c;
    logic              flag_z;
    logic [2:0]        bus_sel;
    logic              ld_mar;
    logic              ld_ir;
    logic              ld_a;
    logic              ld_b;
    logic              ld_out;
    logic              ld_flags;
    logic              pc_inc;
    logic              pc_ld;
    logic              mem_we;
    logic              alu_sub;
    logic [2:0]        tstate;
    logic              halted;

    modport master (
        input  instr, flag_c, flag_z,
        output bus_sel, ld_mar, ld_ir, ld_a, ld_b, ld_out, ld_flags,
        output pc_inc, pc_ld, mem_we, alu_sub, tstate, halted
    );

    modport slave (
        output instr, flag_c, flag_z,
        input  bus_sel, ld_mar, ld_ir, ld_a, ld_b, ld_out, ld_flags,
        input  pc_inc, pc_ld, mem_we, alu_sub, tstate, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded fetch/decode/execute sequencer for the 8-bit computer.
// Optional SINGLE_STEP_EN adds step_mode/step inputs for manual T-state stepping.
module control_sequencer #(
    parameter int DATA_W = 8,
    parameter int OPND_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef SINGLE_STEP_EN
    input  logic step_mode,
    input  logic step,
`endif
    control_sequencer_if.master bus
);
    localparam int OPC_W = DATA_W - OPND_W;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_IN  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    localparam logic [2:0] SEL_PC   = 3'd0;
    localparam logic [2:0] SEL_RAM  = 3'd1;
    localparam logic [2:0] SEL_OPND = 3'd2;
    localparam logic [2:0] SEL_A    = 3'd3;
    localparam logic [2:0] SEL_ALU  = 3'd4;
    localparam logic [2:0] SEL_IN   = 3'd6;
    localparam logic [2:0] SEL_IDLE = 3'd7;

    logic [OPC_W-1:0] opcode_s;
    logic [2:0]       tstate_q, tstate_d;
    logic             halted_q, halted_d;
    logic             advance_s;

    // Raw microcode decode, before reset/halt/step gating.
    logic [2:0] sel_s;
    logic       mar_s, ir_s, a_s, b_s, out_s, flg_s, inc_s, pld_s, we_s, sub_s;
    logic       kill_s;

    assign opcode_s = bus.instr[DATA_W-1:OPND_W];

`ifdef SINGLE_STEP_EN
    logic step_q;

    // Step input history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign advance_s = !step_mode || (step && !step_q);
`else
    assign advance_s = 1'b1;
`endif

    // Next T-state and halt decision.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (halted_q) begin
            tstate_d = 3'd2;
        end else if (tstate_q > 3'd4) begin
            tstate_d = 3'd0;
        end else if (!advance_s) begin
            tstate_d = tstate_q;
        end else begin
            case (tstate_q)
                3'd0: tstate_d = 3'd1;
                3'd1: tstate_d = 3'd2;
                3'd2: begin
                    if (opcode_s == OP_LDA || opcode_s == OP_ADD ||
                        opcode_s == OP_SUB || opcode_s == OP_STA) begin
                        tstate_d = 3'd3;
                    end else if (opcode_s == OP_HLT) begin
                        tstate_d = 3'd2;
                        halted_d = 1'b1;
                    end else begin
                        tstate_d = 3'd0;
                    end
                end
                3'd3: begin
                    if (opcode_s == OP_ADD || opcode_s == OP_SUB) begin
                        tstate_d = 3'd4;
                    end else begin
                        tstate_d = 3'd0;
                    end
                end
                default: tstate_d = 3'd0;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // Microcode: bus source and strobes for the current T-state.
    always_comb begin
        sel_s = SEL_IDLE;
        mar_s = 1'b0; ir_s  = 1'b0; a_s   = 1'b0; b_s   = 1'b0; out_s = 1'b0;
        flg_s = 1'b0; inc_s = 1'b0; pld_s = 1'b0; we_s  = 1'b0; sub_s = 1'b0;
        case (tstate_q)
            3'd0: begin
                sel_s = SEL_PC;
                mar_s = 1'b1;
            end
            3'd1: begin
                sel_s = SEL_RAM;
                ir_s  = 1'b1;
                inc_s = 1'b1;
            end
            3'd2: begin
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        sel_s = SEL_OPND;
                        mar_s = 1'b1;
                    end
                    OP_LDI: begin
                        sel_s = SEL_OPND;
                        a_s   = 1'b1;
                    end
                    OP_JMP: begin
                        sel_s = SEL_OPND;
                        pld_s = 1'b1;
                    end
                    OP_JC: begin
                        if (bus.flag_c) begin
                            sel_s = SEL_OPND;
                            pld_s = 1'b1;
                        end else begin
                            sel_s = SEL_IDLE;
                        end
                    end
                    OP_JZ: begin
                        if (bus.flag_z) begin
                            sel_s = SEL_OPND;
                            pld_s = 1'b1;
                        end else begin
                            sel_s = SEL_IDLE;
                        end
                    end
                    OP_IN: begin
                        sel_s = SEL_IN;
                        a_s   = 1'b1;
                    end
                    OP_OUT: begin
                        sel_s = SEL_A;
                        out_s = 1'b1;
                    end
                    default: sel_s = SEL_IDLE;
                endcase
            end
            3'd3: begin
                case (opcode_s)
                    OP_LDA: begin
                        sel_s = SEL_RAM;
                        a_s   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        sel_s = SEL_RAM;
                        b_s   = 1'b1;
                        sub_s = (opcode_s == OP_SUB);
                    end
                    OP_STA: begin
                        sel_s = SEL_A;
                        we_s  = 1'b1;
                    end
                    default: sel_s = SEL_IDLE;
                endcase
            end
            3'd4: begin
                if (opcode_s == OP_ADD || opcode_s == OP_SUB) begin
                    sel_s = SEL_ALU;
                    a_s   = 1'b1;
                    flg_s = 1'b1;
                    sub_s = (opcode_s == OP_SUB);
                end else begin
                    sel_s = SEL_IDLE;
                end
            end
            default: sel_s = SEL_IDLE;
        endcase
    end

    // Reset and halt silence everything; a held step only suppresses the loads.
    assign kill_s = rst || halted_q || !advance_s;

    assign bus.bus_sel  = (rst || halted_q) ? SEL_IDLE : sel_s;
    assign bus.ld_mar   = mar_s && !kill_s;
    assign bus.ld_ir    = ir_s  && !kill_s;
    assign bus.ld_a     = a_s   && !kill_s;
    assign bus.ld_b     = b_s   && !kill_s;
    assign bus.ld_out   = out_s && !kill_s;
    assign bus.ld_flags = flg_s && !kill_s;
    assign bus.pc_inc   = inc_s && !kill_s;
    assign bus.pc_ld    = pld_s && !kill_s;
    assign bus.mem_we   = we_s  && !kill_s;
    assign bus.alu_sub  = sub_s && !kill_s;
    assign bus.tstate   = tstate_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expectations queued at drive time,
// compared on the falling edge.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if ifc ();

`ifdef SINGLE_STEP_EN
    logic step_mode = 1'b0;
    logic step      = 1'b0;
    logic pend_mode = 1'b0;
    logic pend_step = 1'b0;
    control_sequencer dut (.clk(clk), .rst(rst), .step_mode(step_mode), .step(step), .bus(ifc.master));
`else
    control_sequencer dut (.clk(clk), .rst(rst), .bus(ifc.master));
`endif

    // Strobe vector: {ld_mar, ld_ir, ld_a, ld_b, ld_out, ld_flags, pc_inc, pc_ld, mem_we, alu_sub}
    localparam logic [9:0] MAR = 10'h200, IR  = 10'h100, LA  = 10'h080, LB  = 10'h040;
    localparam logic [9:0] OUT = 10'h020, FLG = 10'h010, INC = 10'h008, PLD = 10'h004;
    localparam logic [9:0] WE  = 10'h002, SUB = 10'h001, NONE = 10'h000;

    typedef struct {
        string      name;
        logic [2:0] sel;
        logic [9:0] st;
        logic [2:0] ts;
        logic       hlt;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] instr;
        logic       fc;
        logic       fz;
        int         n;
        logic [2:0] sel2, sel3, sel4;
        logic [9:0] st2, st3, st4;
    } ins_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard: compare the oldest expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            e = sb.pop_front();
            act = {ifc.ld_mar, ifc.ld_ir, ifc.ld_a, ifc.ld_b, ifc.ld_out, ifc.ld_flags,
                   ifc.pc_inc, ifc.pc_ld, ifc.mem_we, ifc.alu_sub};
            n_checks++;
            if (ifc.bus_sel !== e.sel || act !== e.st || ifc.tstate !== e.ts || ifc.halted !== e.hlt) begin
                n_fail++;
                $display("FAIL %s: got sel=%0d strobes=%h ts=%0d halted=%b, want sel=%0d strobes=%h ts=%0d halted=%b",
                         e.name, ifc.bus_sel, act, ifc.tstate, ifc.halted, e.sel, e.st, e.ts, e.hlt);
            end
        end
    end

    task automatic cyc(input logic r, input logic [7:0] ins, input logic c, input logic z,
                       input string nm, input logic [2:0] sel, input logic [9:0] st,
                       input logic [2:0] ts, input logic h);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        ifc.instr = ins;
        ifc.flag_c = c;
        ifc.flag_z = z;
`ifdef SINGLE_STEP_EN
        step_mode = pend_mode;
        step = pend_step;
`endif
        e.name = nm; e.sel = sel; e.st = st; e.ts = ts; e.hlt = h;
        sb.push_back(e);
    endtask

    task automatic run_ins(input ins_t t);
        cyc(1'b0, t.instr, t.fc, t.fz, {t.name, "_T0"}, 3'd0, MAR, 3'd0, 1'b0);
        cyc(1'b0, t.instr, t.fc, t.fz, {t.name, "_T1"}, 3'd1, IR | INC, 3'd1, 1'b0);
        cyc(1'b0, t.instr, t.fc, t.fz, {t.name, "_T2"}, t.sel2, t.st2, 3'd2, 1'b0);
        if (t.n >= 4) cyc(1'b0, t.instr, t.fc, t.fz, {t.name, "_T3"}, t.sel3, t.st3, 3'd3, 1'b0);
        if (t.n >= 5) cyc(1'b0, t.instr, t.fc, t.fz, {t.name, "_T4"}, t.sel4, t.st4, 3'd4, 1'b0);
    endtask

    function automatic ins_t mk(input string nm, input logic [7:0] ins, input logic c, input logic z,
                                input int n, input logic [2:0] s2, input logic [9:0] t2,
                                input logic [2:0] s3, input logic [9:0] t3,
                                input logic [2:0] s4, input logic [9:0] t4);
        ins_t t;
        t.name = nm; t.instr = ins; t.fc = c; t.fz = z; t.n = n;
        t.sel2 = s2; t.st2 = t2; t.sel3 = s3; t.st3 = t3; t.sel4 = s4; t.st4 = t4;
        return t;
    endfunction

    ins_t tbl[15];

    initial begin
        tbl[0]  = mk("LDI",    8'h57, 1'b0, 1'b0, 3, 3'd2, LA,       3'd7, NONE,     3'd7, NONE);
        tbl[1]  = mk("SUB",    8'h3A, 1'b0, 1'b0, 5, 3'd2, MAR,      3'd1, LB | SUB, 3'd4, LA | FLG | SUB);
        tbl[2]  = mk("JC_nc",  8'h7C, 1'b0, 1'b1, 3, 3'd7, NONE,     3'd7, NONE,     3'd7, NONE);
        tbl[3]  = mk("JC_c",   8'h7C, 1'b1, 1'b0, 3, 3'd2, PLD,      3'd7, NONE,     3'd7, NONE);
        tbl[4]  = mk("JZ_nz",  8'h83, 1'b1, 1'b0, 3, 3'd7, NONE,     3'd7, NONE,     3'd7, NONE);
        tbl[5]  = mk("JZ_z",   8'h83, 1'b0, 1'b1, 3, 3'd2, PLD,      3'd7, NONE,     3'd7, NONE);
        tbl[6]  = mk("LDA",    8'h1E, 1'b0, 1'b0, 4, 3'd2, MAR,      3'd1, LA,       3'd7, NONE);
        tbl[7]  = mk("ADD",    8'h2F, 1'b1, 1'b1, 5, 3'd2, MAR,      3'd1, LB,       3'd4, LA | FLG);
        tbl[8]  = mk("STA",    8'h40, 1'b0, 1'b0, 4, 3'd2, MAR,      3'd3, WE,       3'd7, NONE);
        tbl[9]  = mk("JMP",    8'h65, 1'b0, 1'b0, 3, 3'd2, PLD,      3'd7, NONE,     3'd7, NONE);
        tbl[10] = mk("IN",     8'h90, 1'b0, 1'b0, 3, 3'd6, LA,       3'd7, NONE,     3'd7, NONE);
        tbl[11] = mk("OUT",    8'hE0, 1'b0, 1'b0, 3, 3'd3, OUT,      3'd7, NONE,     3'd7, NONE);
        tbl[12] = mk("NOP",    8'h0F, 1'b1, 1'b1, 3, 3'd7, NONE,     3'd7, NONE,     3'd7, NONE);
        tbl[13] = mk("UNDEF",  8'hB3, 1'b1, 1'b1, 3, 3'd7, NONE,     3'd7, NONE,     3'd7, NONE);
        tbl[14] = mk("LDI_end",8'h50, 1'b0, 1'b0, 3, 3'd2, LA,       3'd7, NONE,     3'd7, NONE);

        ifc.instr = 8'h57; ifc.flag_c = 1'b0; ifc.flag_z = 1'b0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h57, 1'b0, 1'b0, "reset", 3'd7, NONE, 3'd0, 1'b0);

        foreach (tbl[i]) run_ins(tbl[i]);

        // HLT: freezes at T2 with everything idle until reset.
        cyc(1'b0, 8'hF0, 1'b0, 1'b0, "HLT_T0", 3'd0, MAR, 3'd0, 1'b0);
        cyc(1'b0, 8'hF0, 1'b0, 1'b0, "HLT_T1", 3'd1, IR | INC, 3'd1, 1'b0);
        cyc(1'b0, 8'hF0, 1'b0, 1'b0, "HLT_T2", 3'd7, NONE, 3'd2, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h3A, 1'b1, 1'b1, "halted", 3'd7, NONE, 3'd2, 1'b1);
        cyc(1'b1, 8'h57, 1'b0, 1'b0, "halt_rst", 3'd7, NONE, 3'd2, 1'b1);
        cyc(1'b0, 8'h57, 1'b0, 1'b0, "halt_exit_T0", 3'd0, MAR, 3'd0, 1'b0);
        cyc(1'b0, 8'h57, 1'b0, 1'b0, "halt_exit_T1", 3'd1, IR | INC, 3'd1, 1'b0);
        cyc(1'b0, 8'h57, 1'b0, 1'b0, "halt_exit_T2", 3'd2, LA, 3'd2, 1'b0);

        // Reset during ADD T3: no ld_b/ld_a/ld_flags, restart at T0.
        cyc(1'b0, 8'h21, 1'b0, 1'b0, "abort_T0", 3'd0, MAR, 3'd0, 1'b0);
        cyc(1'b0, 8'h21, 1'b0, 1'b0, "abort_T1", 3'd1, IR | INC, 3'd1, 1'b0);
        cyc(1'b0, 8'h21, 1'b0, 1'b0, "abort_T2", 3'd2, MAR, 3'd2, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0, "abort_rst_T3", 3'd7, NONE, 3'd3, 1'b0);
        cyc(1'b0, 8'h21, 1'b0, 1'b0, "abort_after", 3'd0, MAR, 3'd0, 1'b0);
        cyc(1'b0, 8'h21, 1'b0, 1'b0, "abort_after_T1", 3'd1, IR | INC, 3'd1, 1'b0);

`ifdef SINGLE_STEP_EN
        // One advance per step rise, loads only in the advancing cycle.
        cyc(1'b1, 8'h00, 1'b0, 1'b0, "ss_rst", 3'd7, NONE, 3'd2, 1'b0);
        pend_mode = 1'b1; pend_step = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_wait", 3'd0, NONE, 3'd0, 1'b0);
        pend_step = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_rise", 3'd0, MAR, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_hold", 3'd1, NONE, 3'd1, 1'b0);
        pend_mode = 1'b0; pend_step = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_off_T1", 3'd1, IR | INC, 3'd1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_off_T2", 3'd7, NONE, 3'd2, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "ss_off_T0", 3'd0, MAR, 3'd0, 1'b0);
`endif

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded fetch/decode/execute controller for the 8-bit computer.
- Drives the 3-bit source select of the 8:1 data bus mux and every register load/enable strobe in the datapath.
- Sits directly upstream of the bus mux; consumes the instruction register contents and the carry/zero flags.
- One instruction executes as 3-5 T-states with early return to fetch.

Parameters:
- DATA_W, 8, data bus / instruction width.
- OPND_W, 4, operand field width (low bits of instruction); opcode = instr[DATA_W-1:OPND_W].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  DATA_W  current instruction register contents.
- flag_c  input  1  registered carry flag.
- flag_z  input  1  registered zero flag.
- bus_sel  output  3  bus source: 0 PC, 1 RAM, 2 IR operand, 3 A, 4 ALU, 5 B, 6 IN port, 7 idle (mux input tied 0).
- ld_mar, ld_ir, ld_a, ld_b, ld_out, ld_flags  output  1 each  register load strobes (load on the clk edge ending the T-state).
- pc_inc, pc_ld, mem_we, alu_sub  output  1 each  PC increment, PC load from bus, RAM write, ALU subtract select.
- tstate  output  3  current T-state, 0-4.
- halted  output  1  high in HALT state.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Registered state: tstate, halted. All other outputs are a combinational decode of tstate, instr and flags.
- Reset: while rst=1, all strobes = 0, bus_sel = 7. On the first edge with rst=1: tstate <= 0, halted <= 0.
  - rst mid-instruction aborts it at once; no partial strobe issues after the asserting edge.
- Inactive default: bus_sel = 7 in any T-state with no bus driver. Every strobe not listed below = 0.
- Fetch, all opcodes:
  - T0: bus_sel=0, ld_mar.
  - T1: bus_sel=1, ld_ir, pc_inc.
- Execute (opcode hex). The listed final step returns tstate to 0 on the next edge. Opcodes without an execute step return to 0 after T2.
  - 0 NOP: T2 none.
  - 1 LDA: T2 sel=2 ld_mar; T3 sel=1 ld_a.
  - 2 ADD: T2 sel=2 ld_mar; T3 sel=1 ld_b; T4 sel=4 ld_a ld_flags.
  - 3 SUB: same as ADD; alu_sub=1 during T3 and T4.
  - 4 STA: T2 sel=2 ld_mar; T3 sel=3 mem_we.
  - 5 LDI: T2 sel=2 ld_a. Operand is zero-extended to DATA_W.
  - 6 JMP: T2 sel=2 pc_ld.
  - 7 JC: T2 sel=2 pc_ld only if flag_c=1; otherwise T2 idle. Takes 3 T-states either way.
  - 8 JZ: same as JC, using flag_z.
  - 9 IN: T2 sel=6 ld_a.
  - E OUT: T2 sel=3 ld_out.
  - F HLT: at T2, halted <= 1 on the edge.
  - A-D undefined: behave as NOP.
- HALT state: tstate frozen at 2, all strobes 0, bus_sel=7. Only rst exits it.
- Flags are sampled combinationally in T2. Their value at T2 decides the jump.
- Invariant: at most one bus-driving source is selected per cycle. mem_we and ld_ir are never asserted in the same cycle.
- tstate never exceeds 4. Any illegal value (5-7) forces the next state to 0.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: adds inputs step_mode (1b) and step (1b).
  - When step_mode=1, tstate advances only in a cycle where step rose (internal 1-cycle edge detect; step register resets to 0).
  - Strobes are gated to 0 in non-advancing cycles, so each T-state's loads occur exactly once.
  - When step_mode=0, behaviour is identical to the macro-undefined build.
- Undefined: ports absent; sequencer advances every clock.

Test Plan:
- Reset: hold rst 3 cycles, release -> all strobes 0 and bus_sel=7 during reset; first cycle after release tstate=0, bus_sel=0, ld_mar=1.
- LDI: instr=0x57 -> T0 sel0 ld_mar; T1 sel1 ld_ir pc_inc; T2 sel2 ld_a; next cycle tstate=0 (3 cycles total).
- SUB: instr=0x3A -> T2 sel2 ld_mar; T3 sel1 ld_b alu_sub=1; T4 sel4 ld_a ld_flags alu_sub=1; 5 cycles total.
- Conditional jump: instr=0x7C with flag_c=0 -> T2 pc_ld=0, bus_sel=7. Same with flag_c=1 -> T2 sel2 pc_ld=1. Both return to T0 after 3 cycles.
- HLT then reset: instr=0xF0 -> halted=1 after T2, strobes stay 0 for 20 cycles. Then assert rst during halt -> halted=0, resumes fetch at T0.
- Reset mid-ADD: assert rst in T3 -> no ld_a/ld_flags pulse occurs; after release restarts at T0. SINGLE_STEP_EN build: step_mode=1, step held high 5 cycles -> exactly one tstate advance.
